// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the multi-requester UART transmit scheduler.
package uart_tx_sched_pkg;

    localparam int NUM_REQ = 4;
    localparam int GRANT_W = $clog2(NUM_REQ);

    typedef logic [GRANT_W-1:0] grant_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    // Advance a requester index by one, wrapping from the last requester back to 0.
    function automatic grant_idx_t next_idx(input grant_idx_t idx);
        grant_idx_t nxt;
        if (idx == grant_idx_t'(NUM_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + grant_idx_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the pointer, wrapping around, and reports it one-hot and encoded.
module uart_rr_arbiter
    import uart_tx_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  grant_idx_t         ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output grant_idx_t         index
);

    logic       found;
    grant_idx_t cand;

    // Walk the requesters starting at the pointer and take the first one that is asking.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
            cand = next_idx(cand);
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit serializer among several byte requesters.
// Arbitration happens only while idle; the granted byte is latched and framed
// as start, data LSB-first, optional even parity, then one or two stop bits.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                          pclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx,
    output logic                          bclk,
    output logic                          busy,
    output grant_idx_t                    grant_id
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);
    localparam int          DIDX_W    = $clog2(DATA_WIDTH);

    tx_state_t               state;
    tx_state_t               state_next;
    grant_idx_t              ptr;
    grant_idx_t              grant_id_q;
    logic [15:0]             baud_cnt;
    logic [3:0]              bit_cnt;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   req_slice;
    logic [NUM_REQ-1:0]      arb_grant;
    grant_idx_t              arb_idx;
    logic                    arb_en;
    logic                    handshake;
    logic                    bit_end;

    // Only offer grants while idle and out of reset, so req_ready drops with reset immediately.
    assign arb_en    = (state == S_IDLE) && areset;
    assign handshake = |arb_grant;
    assign req_ready = arb_grant;

    uart_rr_arbiter u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (arb_en),
        .grant  (arb_grant),
        .index  (arb_idx)
    );

    // The last pclk of each bit time is the only moment the frame may advance.
    assign bit_end  = (state != S_IDLE) && (baud_cnt == BAUD_LAST);
    assign bclk     = bit_end;
    assign busy     = (state != S_IDLE);
    assign grant_id = grant_id_q;

    // Select the winning requester's byte slice for latching at the handshake.
    always_comb begin
        req_slice = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == grant_idx_t'(i)) begin
                req_slice = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register; reset abandons any frame in flight and returns the line to idle-high.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and the serial line value for the current frame slot.
    always_comb begin
        state_next = state;
        tx         = 1'b1;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                tx = data_q[bit_cnt[DIDX_W-1:0]];
                if (bit_end && (bit_cnt == DATA_LAST)) begin
                    state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                tx = ^data_q;
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                tx = 1'b1;
                if (bit_end && (bit_cnt == STOP_LAST)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake capture, round-robin pointer, baud divider and per-state bit counter.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            ptr        <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
        end else if (state == S_IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (handshake) begin
                data_q     <= req_slice;
                grant_id_q <= arb_idx;
                ptr        <= next_idx(arb_idx);
            end
        end else begin
            baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
            if (bit_end) begin
                bit_cnt <= (state_next != state) ? 4'd0 : bit_cnt + 4'd1;
            end
        end
    end

endmodule
